// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and the buffered write-back entry type
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// wb_fifo: write-back buffer with two push ports (push0 older), one pop port and age-ordered lookup views; data lookup only with WB_FORWARD_EN
module wb_fifo import regfile_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push0_i,
  input  wb_entry_t                            push0_ent_i,
  input  logic                                 push1_i,
  input  wb_entry_t                            push1_ent_i,
  input  logic                                 pop_i,
  output wb_entry_t                            head_o,
  output logic [CW-1:0]                        count_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     age_rd_o,
`ifdef WB_FORWARD_EN
  output logic [DEPTH-1:0][XLEN-1:0]           age_data_o,
`endif
  output logic [DEPTH-1:0]                     age_vld_o
);
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_nx;
  logic [CW-1:0] count_q, count_d, npush;
  wb_entry_t     mem_q [DEPTH];

  // pointer and occupancy next state; a lone push1 lands at the write pointer
  always_comb begin
    npush   = CW'(push0_i) + CW'(push1_i);
    wptr_nx = wptr_q + AW'(1);
    wptr_d  = wptr_q + AW'(npush);
    rptr_d  = pop_i ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + npush - CW'(pop_i);
  end

  // pointers and count, cleared asynchronously so buffered entries are discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // storage needs no reset: validity comes from the pointers and count
  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wptr_q] <= push0_ent_i;
    if (push1_i) mem_q[push0_i ? wptr_nx : wptr_q] <= push1_ent_i;
  end

  // slot g of the lookup view is the g-th oldest entry
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    assign age_rd_o[g]  = mem_q[rptr_q + AW'(g)].rd;
    assign age_vld_o[g] = CW'(g) < count_q;
`ifdef WB_FORWARD_EN
    assign age_data_o[g] = mem_q[rptr_q + AW'(g)].data;
`endif
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges load and ALU results into one register-file write port with hazard query; forwarding data via WB_FORWARD_EN
module regfile_writeback import regfile_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  output logic                  q_rs1_pending,
  output logic                  q_rs2_pending,
  output logic [XLEN-1:0]       q_rs1_fwd_data,
  output logic [XLEN-1:0]       q_rs2_fwd_data,
  output logic [CW-1:0]         count
);
  logic                             ld_push, alu_push, pop;
  logic                             rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0]            rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]                  rf_wdata_q, rf_wdata_d;
  wb_entry_t                        ld_ent, alu_ent, head;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] age_rd;
  logic [DEPTH-1:0]                 age_vld;
  logic [REG_ADDR_W-1:0]            qs [2];
  logic [1:0]                       pend;
`ifdef WB_FORWARD_EN
  logic [DEPTH-1:0][XLEN-1:0]       age_data;
  logic [XLEN-1:0]                  fwd [2];
`endif

  // readiness depends on registered occupancy only, so no valid-to-ready path exists
  assign ld_ready  = count <= CW'(DEPTH - 1);
  assign alu_ready = count <= CW'(DEPTH - 2);
  assign ld_push   = ld_valid & ld_ready & (ld_rd != '0);
  assign alu_push  = alu_valid & alu_ready & (alu_rd != '0);
  assign pop       = count != '0;
  assign ld_ent    = '{rd: ld_rd, data: ld_data};
  assign alu_ent   = '{rd: alu_rd, data: alu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push0_i    (ld_push),
    .push0_ent_i(ld_ent),
    .push1_i    (alu_push),
    .push1_ent_i(alu_ent),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .age_rd_o   (age_rd),
`ifdef WB_FORWARD_EN
    .age_data_o (age_data),
`endif
    .age_vld_o  (age_vld)
  );

  // head moves into the write register whenever the buffer held something before this edge
  always_comb begin
    rf_we_d    = pop;
    rf_rd_d    = pop ? head.rd : rf_rd_q;
    rf_wdata_d = pop ? head.data : rf_wdata_q;
  end

  // register-file write port, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign qs[0]    = q_rs1;
  assign qs[1]    = q_rs2;

  // hazard lookup: write register is oldest, later buffer slots override so the newest match wins
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      pend[q] = (|qs[q]) && rf_we_q && rf_rd_q == qs[q];
`ifdef WB_FORWARD_EN
      fwd[q] = pend[q] ? rf_wdata_q : '0;
`endif
      for (int k = 0; k < DEPTH; k++)
        if ((|qs[q]) && age_vld[k] && age_rd[k] == qs[q]) begin
          pend[q] = 1'b1;
`ifdef WB_FORWARD_EN
          fwd[q] = age_data[k];
`endif
        end
    end
  end

  assign q_rs1_pending = pend[0];
  assign q_rs2_pending = pend[1];
`ifdef WB_FORWARD_EN
  assign q_rs1_fwd_data = fwd[0];
  assign q_rs2_fwd_data = fwd[1];
`else
  assign q_rs1_fwd_data = '0;
  assign q_rs2_fwd_data = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: scoreboard bench with a queue-based reference model, directed and random stimulus
module tb_regfile_writeback;
  import regfile_pkg::*;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ld_valid = 0, alu_valid = 0, ld_ready, alu_ready, rf_we;
  logic [4:0]  ld_rd = 0, alu_rd = 0, rf_rd, q_rs1 = 0, q_rs2 = 0;
  logic [31:0] ld_data = 0, alu_data = 0, rf_wdata, q_rs1_fwd_data, q_rs2_fwd_data;
  logic        q_rs1_pending, q_rs2_pending;
  logic [2:0]  count;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .q_rs1(q_rs1), .q_rs2(q_rs2),
    .q_rs1_pending(q_rs1_pending), .q_rs2_pending(q_rs2_pending),
    .q_rs1_fwd_data(q_rs1_fwd_data), .q_rs2_fwd_data(q_rs2_fwd_data),
    .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: buffer contents, last write-port value, expected-write scoreboard
  wb_entry_t   mq[$], sb[$];
  logic        m_we = 0, ld_done = 0, alu_done = 0;
  logic [4:0]  m_rd = 0;
  logic [31:0] m_data = 0;

  function automatic logic exp_pend(logic [4:0] q);
    if (q == 0) return 1'b0;
    if (m_we && m_rd == q) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_fwd(logic [4:0] q);
`ifdef WB_FORWARD_EN
    if (q == 0) return 32'h0;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].rd == q) return mq[i].data;
    if (m_we && m_rd == q) return m_data;
`endif
    return 32'h0;
  endfunction

  initial begin : model
    wb_entry_t e;
    int free;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete(); sb.delete();
        m_we = 0; m_rd = 0; m_data = 0; ld_done = 0; alu_done = 0;
      end else begin
        free = DEPTH - mq.size();
        ld_done  = ld_valid && free >= 1;
        alu_done = alu_valid && free >= 2;
        if (mq.size() > 0) begin
          e = mq.pop_front();
          m_we = 1; m_rd = e.rd; m_data = e.data;
        end else m_we = 0;
        if (ld_done && ld_rd != 0) begin
          mq.push_back('{rd: ld_rd, data: ld_data});
          sb.push_back('{rd: ld_rd, data: ld_data});
        end
        if (alu_done && alu_rd != 0) begin
          mq.push_back('{rd: alu_rd, data: alu_data});
          sb.push_back('{rd: alu_rd, data: alu_data});
        end
      end
    end
  end

  // monitor: every write the DUT presents must be the oldest expected write
  initial begin : monitor
    wb_entry_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        chk("count", count, mq.size());
        chk("ld_ready", ld_ready, mq.size() <= DEPTH - 1);
        chk("alu_ready", alu_ready, mq.size() + 2 <= DEPTH);
        chk("rf_we", rf_we, m_we);
        if (rf_we) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: rf_rd=%0d rf_wdata=0x%0h, nothing expected", rf_rd, rf_wdata);
          end else begin
            e = sb.pop_front();
            chk("rf_rd", rf_rd, e.rd);
            chk("rf_wdata", rf_wdata, e.data);
          end
        end
        chk("q_rs1_pending", q_rs1_pending, exp_pend(q_rs1));
        chk("q_rs2_pending", q_rs2_pending, exp_pend(q_rs2));
        chk("q_rs1_fwd", q_rs1_fwd_data, exp_fwd(q_rs1));
        chk("q_rs2_fwd", q_rs2_fwd_data, exp_fwd(q_rs2));
      end
    end
  end

  task automatic cyc(logic lv, logic [4:0] lr, logic [31:0] ldt, logic av, logic [4:0] ar, logic [31:0] adt);
    @(negedge clk);
    ld_valid = lv; ld_rd = lr; ld_data = ldt;
    alu_valid = av; alu_rd = ar; alu_data = adt;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #3;
  endtask

  task automatic rand_phase(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!ld_valid || ld_done) begin
        ld_valid = 1'($urandom_range(0, 1)); ld_rd = 5'($urandom_range(0, 9)); ld_data = $urandom;
      end
      if (!alu_valid || alu_done) begin
        alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'($urandom_range(0, 9)); alu_data = $urandom;
      end
      q_rs1 = 5'($urandom_range(0, 9));
      q_rs2 = 5'($urandom_range(0, 9));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int issued, peak;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q_rs1 = 5; q_rs2 = 3;
    #1;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pend1", q_rs1_pending, 0);
    chk("rst_pend2", q_rs2_pending, 0);
    chk("rst_fwd1", q_rs1_fwd_data, 0);
    chk("rst_fwd2", q_rs2_fwd_data, 0);

    // single load: visible on the write port only after the second edge
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0);
    after_edge();
    chk("lat_we_edge1", rf_we, 0);
    chk("lat_count_edge1", count, 1);
    cyc(0, 0, 0, 0, 0, 0);
    after_edge();
    chk("lat_we_edge2", rf_we, 1);
    chk("lat_rd_edge2", rf_rd, 5);
    chk("lat_data_edge2", rf_wdata, 32'hDEADBEEF);
    after_edge();
    chk("lat_we_edge3", rf_we, 0);

    // simultaneous load and ALU: load is older
    cyc(1, 3, 32'h11, 1, 4, 32'h22);
    after_edge();
    chk("dual_count", count, 2);
    cyc(0, 0, 0, 0, 0, 0);
    after_edge();
    chk("dual_first_rd", rf_rd, 3);
    chk("dual_first_data", rf_wdata, 32'h11);
    after_edge();
    chk("dual_second_we", rf_we, 1);
    chk("dual_second_rd", rf_rd, 4);
    chk("dual_second_data", rf_wdata, 32'h22);

    // rd 0 completes the handshake but is dropped
    cyc(0, 0, 0, 1, 0, 32'h55);
    chk("x0_alu_ready", alu_ready, 1);
    after_edge();
    chk("x0_count", count, 0);
    cyc(0, 0, 0, 0, 0, 0);
    after_edge();
    chk("x0_rf_we", rf_we, 0);

    // two writes to x7: newest value forwarded
    cyc(1, 7, 32'h1, 1, 7, 32'h2);
    q_rs1 = 7; q_rs2 = 0;
    after_edge();
    chk("fwd_pend", q_rs1_pending, 1);
`ifdef WB_FORWARD_EN
    chk("fwd_data", q_rs1_fwd_data, 32'h2);
`else
    chk("fwd_data_off", q_rs1_fwd_data, 32'h0);
`endif
    chk("fwd_x0_pend2", q_rs2_pending, 0);
    q_rs1 = 0;
    #1;
    chk("fwd_x0_pend1", q_rs1_pending, 0);
    chk("fwd_x0_data1", q_rs1_fwd_data, 0);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (3) after_edge();

    // flood both channels: 20 transfers across pointer wrap
    issued = 0; peak = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (int'(count) > peak) peak = int'(count);
      if (count == 3) chk("flood_alu_block", alu_ready, 0);
      if (!ld_valid || ld_done) begin
        if (issued < 20) begin
          ld_valid = 1; ld_rd = 5'(1 + issued % 31); ld_data = 32'hA000 + 32'(issued); issued++;
        end else ld_valid = 0;
      end
      if (!alu_valid || alu_done) begin
        if (issued < 20) begin
          alu_valid = 1; alu_rd = 5'(1 + issued % 31); alu_data = 32'hA000 + 32'(issued); issued++;
        end else alu_valid = 0;
      end
      if (issued == 20 && !ld_valid && !alu_valid) break;
    end
    chk("flood_issued", 32'(issued), 20);
    chk("flood_peak", 32'(peak), 3);
    for (int c = 0; c < 20 && sb.size() != 0; c++) after_edge();
    chk("flood_drained", 32'(sb.size()), 0);

    // asynchronous reset with three entries buffered
    cyc(1, 9, 32'h91, 1, 10, 32'h92);
    cyc(1, 11, 32'h93, 1, 12, 32'h94);
    after_edge();
    chk("rst_pre_count", count, 3);
    ld_valid = 0; alu_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_count", count, 0);
    chk("rst_mid_we", rf_we, 0);
    chk("rst_mid_ld_ready", ld_ready, 1);
    chk("rst_mid_alu_ready", alu_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      after_edge();
      chk("rst_no_stale_we", rf_we, 0);
    end

    rand_phase(3000);
    @(negedge clk);
    ld_valid = 0; alu_valid = 0;
    repeat (8) after_edge();
    chk("final_drained", 32'(sb.size()), 0);
    chk("final_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
